// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-deep stereo holding register feeding a frame-aligned
// active pair, shifted out MSB first with the standard one-bit delay after ws changes.
module i2s_tx_serializer #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SAMPLE_BITS-1:0] in_left,
    input  logic [SAMPLE_BITS-1:0] in_right,
    output logic                   ws,
    output logic                   sd,
    output logic                   frame_start,
    output logic                   underflow
);

    localparam int unsigned FrameLen = 2 * SLOT_BITS;
    localparam int unsigned PW       = $clog2(FrameLen);
    localparam int unsigned IW       = $clog2(SAMPLE_BITS);
    localparam logic [PW-1:0] PLast  = PW'(FrameLen - 1);

    logic [PW-1:0]          p_q, p_d;
    logic [SAMPLE_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic                   hold_full_q, hold_full_d;
    logic                   ws_q, ws_d;
    logic                   sd_q, sd_d;
    logic                   underflow_q, underflow_d;

    logic                   transfer;
    logic                   frame_load;
    int unsigned            pos;

    always_comb begin
        p_d         = p_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        ws_d        = 1'b0;
        sd_d        = 1'b0;

        transfer    = in_valid && !hold_full_q;
        frame_load  = en && (p_q == PLast);
        underflow_d = frame_load && !hold_full_q;

        if (en) begin
            p_d = frame_load ? '0 : p_q + PW'(1);
        end

        if (frame_load) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                act_l_d = '0;
                act_r_d = '0;
            end
        end

        // Only possible into an empty holder, so never collides with the load above.
        if (transfer) begin
            hold_l_d    = in_left;
            hold_r_d    = in_right;
            hold_full_d = 1'b1;
        end

        // Outputs are registered against the next position so they align with p_q.
        pos = 32'(p_d);
        if (en) begin
            ws_d = (pos >= SLOT_BITS);
            if (pos != 0 && pos <= SAMPLE_BITS) begin
                sd_d = act_l_d[IW'(SAMPLE_BITS - pos)];
            end else if (pos > SLOT_BITS && pos <= SLOT_BITS + SAMPLE_BITS) begin
                sd_d = act_r_d[IW'(SLOT_BITS + SAMPLE_BITS - pos)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q         <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            ws_q        <= ws_d;
            sd_q        <= sd_d;
            underflow_q <= underflow_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = en && (p_q == '0);
    assign underflow   = underflow_q && en;

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 Parameter SAMPLE_BITS, default 16, width of each PCM sample (two's complement, MSB first on the wire).
REQ-002 Parameter SLOT_BITS, default 32, clocks per half frame (one channel slot); legal only when SLOT_BITS >= SAMPLE_BITS+1.
REQ-003 Port clk  input  1  single clock; all flops update on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  serializer run enable.
REQ-006 Port in_valid  input  1  a stereo sample pair is presented.
REQ-007 Port in_ready  output  1  the holding register can accept a pair.
REQ-008 Port in_left  input  SAMPLE_BITS  left PCM sample.
REQ-009 Port in_right  input  SAMPLE_BITS  right PCM sample.
REQ-010 Port ws  output  1  I2S word select: 0 = left slot, 1 = right slot; registered.
REQ-011 Port sd  output  1  I2S serial data; registered.
REQ-012 Port frame_start  output  1  one-cycle pulse, high while p == 0 and en == 1.
REQ-013 Port underflow  output  1  one-cycle pulse at a frame load with no pair held.

Function
REQ-014 A position counter p SHALL run 0..2*SLOT_BITS-1 and wrap to 0; it SHALL increment by 1 per clock while en == 1 and hold its value while en == 0.
REQ-015 The block SHALL drive ws = 1 exactly when p >= SLOT_BITS.
REQ-016 The block SHALL drive sd with a one-bit I2S delay, using the active pair:
- sd = L[SAMPLE_BITS-p] for p in 1..SAMPLE_BITS.
- sd = R[SAMPLE_BITS-(p-SLOT_BITS)] for p in SLOT_BITS+1..SLOT_BITS+SAMPLE_BITS.
- sd = 0 at every other p.
REQ-017 ws and sd SHALL come directly from flops updated at the same edge as p, so they are valid for the whole cycle in which p holds the corresponding value.
REQ-018 A one-deep holding register SHALL hold one stereo pair; in_ready SHALL equal NOT hold_full, with no combinational path from in_valid.
REQ-019 A transfer SHALL occur on a clock edge where in_valid && in_ready; it SHALL capture in_left/in_right into the holding register and set hold_full.
REQ-020 On the edge where p wraps from 2*SLOT_BITS-1 to 0 (en == 1), the frame load SHALL happen:
- If hold_full: the active pair takes the held pair and hold_full clears.
- Otherwise: the active pair becomes 0/0 and underflow pulses in the following cycle (p == 0).
REQ-021 A transfer and a frame load on the same edge with hold previously empty SHALL be treated as an underflow: the active pair becomes 0/0, and the new pair lands in the holding register for the next frame (no bypass).
REQ-022 While en == 0:
- ws and sd SHALL be driven 0, frame_start and underflow SHALL be 0, and no frame load SHALL occur.
- Transfers into an empty holding register SHALL still be accepted.
REQ-023 When en returns to 1, serialization SHALL resume from the held p value; the bench drives en changes only at p == 0.
REQ-024 Samples SHALL be serialized unmodified: no truncation, saturation or sign extension.

Reset
REQ-025 With reset high at a rising edge:
- p = 0; active pair = 0/0; holding register = 0/0 and empty.
- ws = 0, sd = 0, frame_start = 0, underflow = 0; in_ready = 1 from the next cycle.
REQ-026 Reset SHALL override en and any transfer on the same edge; a pair presented during reset is discarded.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; the first frame after release carries 0/0 unless a pair was accepted before the first wrap.

Verification (SAMPLE_BITS=16, SLOT_BITS=32, frame = 64 clocks)
REQ-028 Reset, en=1, no input -> ws low for 32 cycles then high for 32; sd constantly 0; underflow pulses at each p == 0 from the second frame onward.
REQ-029 Accept L=16'hA5C3, R=16'h8001 during frame 0 -> in frame 1, sd at p=1..16 = 1010010111000011 and at p=33..48 = 1000000000000001; sd = 0 elsewhere; no underflow at the start of frame 1.
REQ-030 Hold in_valid high continuously with distinct pairs -> in_ready drops after each transfer and rises the cycle after each frame load; exactly one pair is consumed per 64 clocks, in order, with no loss or duplication.
REQ-031 Assert in_valid for the first time exactly on the p=63 edge -> underflow pulses at p=0; that frame is silent; the pair plays in the next frame.
REQ-032 Drop en at p=0 for 10 cycles while a pair is held -> ws, sd, frame_start and underflow stay 0; p is frozen; on re-enable the frame plays the held pair with correct bit positions.
REQ-033 Assert reset at p=20 of a frame carrying L=16'hFFFF -> the next cycle shows sd=0, ws=0, in_ready=1; the following frame is 0/0.
